vga_timing: RTL and testbench

- 640x480@60 Hz raster timing generator.
- Produces the col/row/valid pixel coordinates consumed by the lane renderers and colour compositor, plus hsync/vsync for the VGA connector.
- Also emits frame/line strobes and a frame counter, used by game logic to advance note positions once per frame during vertical blanking.

---
 rtl/vga_timing.sv | 101 ++++++++++
 tb/tb_vga_timing.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing.sv
// vga_timing: 640x480@60 raster timing generator with coordinates, syncs, strobes and frame counter.
// Define VGA_OUT_REG_EN to add one output register stage (1 clk latency on every output).
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       line_tick,
    output logic       frame_tick,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
        $error("vga_timing: line or frame total does not fit in 10 bits");
    end

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       line_tick;
        logic       frame_tick;
        logic [7:0] frame_count;
    } out_t;

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [7:0] fcnt_q, fcnt_d;
    logic       h_wrap, v_wrap;
    out_t       out_d;

    always_comb begin
        h_wrap = hcnt_q == H_LAST;
        v_wrap = vcnt_q == V_LAST;
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (pix_en) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 10'd1;
            vcnt_d = !h_wrap ? vcnt_q : v_wrap ? '0 : vcnt_q + 10'd1;
        end
        // Outputs are forced to their idle values for as long as reset is held.
        out_d.col         = reset ? '0 : hcnt_q;
        out_d.row         = reset ? '0 : vcnt_q;
        out_d.valid       = !reset && hcnt_q < H_ACT && vcnt_q < V_ACT;
        out_d.hsync       = reset || !(hcnt_q >= HS_START && hcnt_q < HS_END);
        out_d.vsync       = reset || !(vcnt_q >= VS_START && vcnt_q < VS_END);
        out_d.line_tick   = !reset && pix_en && hcnt_q == '0;
        out_d.frame_tick  = out_d.line_tick && vcnt_q == V_ACT;
        out_d.frame_count = fcnt_q;
        fcnt_d = out_d.frame_tick ? fcnt_q + 8'd1 : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            fcnt_q <= fcnt_d;
        end
    end

`ifdef VGA_OUT_REG_EN
    out_t out_q;

    // Free-running stage: loads the forced values during reset, so it tracks out_d exactly one clk late.
    always_ff @(posedge clk) begin
        out_q <= out_d;
    end

    assign {col, row, valid, hsync, vsync, line_tick, frame_tick, frame_count} = out_q;
`else
    assign {col, row, valid, hsync, vsync, line_tick, frame_tick, frame_count} = out_d;
`endif
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: table-driven checks on a full-size instance plus frame-level sequences on a reduced-size instance.
module tb_vga_timing;
`ifdef VGA_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pix_en = 1'b1;
    always #5 clk = ~clk;

    logic [9:0] col0, row0, col1, row1;
    logic       v0, hs0, vs0, lt0, ft0, v1, hs1, vs1, lt1, ft1;
    logic [7:0] fc0, fc1;

    vga_timing d0 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .col(col0), .row(row0), .valid(v0),
        .hsync(hs0), .vsync(vs0), .line_tick(lt0), .frame_tick(ft0), .frame_count(fc0)
    );

    // Small raster: 8 pixels x 7 lines, hsync low on cols 5..6, vsync low on row 5, frame_tick at row 4.
    vga_timing #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) d1 (
        .clk(clk), .reset(reset), .pix_en(pix_en), .col(col1), .row(row1), .valid(v1),
        .hsync(hs1), .vsync(vs1), .line_tick(lt1), .frame_tick(ft1), .frame_count(fc1)
    );

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       valid;
        logic       hsync;
        logic       vsync;
        logic       line_tick;
        logic       frame_tick;
        logic [7:0] frame_count;
    } obs_t;

    obs_t o0, o1;
    assign o0 = {col0, row0, v0, hs0, vs0, lt0, ft0, fc0};
    assign o1 = {col1, row1, v1, hs1, vs1, lt1, ft1, fc1};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic obs_t mk(int c, int r, bit v, bit hs, bit vs, bit lt, bit ft, int fc);
        obs_t o;
        o.col = 10'(c);
        o.row = 10'(r);
        o.valid = v;
        o.hsync = hs;
        o.vsync = vs;
        o.line_tick = lt;
        o.frame_tick = ft;
        o.frame_count = 8'(fc);
        return o;
    endfunction

    task automatic cmp_obs(string nm, obs_t a, obs_t e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got col=%0d row=%0d valid=%b hs=%b vs=%b lt=%b ft=%b fc=%0d, want col=%0d row=%0d valid=%b hs=%b vs=%b lt=%b ft=%b fc=%0d",
                     nm, a.col, a.row, a.valid, a.hsync, a.vsync, a.line_tick, a.frame_tick, a.frame_count,
                     e.col, e.row, e.valid, e.hsync, e.vsync, e.line_tick, e.frame_tick, e.frame_count);
        end
    endtask

    task automatic cmp_int(string nm, int a, int e);
        n_chk++;
        if (a != e) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", nm, a, e);
        end
    endtask

    // With the output register, expectations are compared one clk after they are raised.
    typedef struct {
        int    stamp;
        bit    inst;
        obs_t  e;
        string nm;
    } pend_t;
    pend_t pend[$];

    task automatic chk(string nm, bit inst, obs_t e);
        if (LAT == 0) cmp_obs(nm, inst ? o1 : o0, e);
        else pend.push_back('{cyc, inst, e, nm});
    endtask

    always @(negedge clk) begin
        while (pend.size() > 0 && pend[0].stamp < cyc) begin
            pend_t p;
            p = pend.pop_front();
            cmp_obs(p.nm, p.inst ? o1 : o0, p.e);
        end
    end

    task automatic tick(bit r, bit p);
        @(posedge clk);
        #1;
        reset = r;
        pix_en = p;
        @(negedge clk);
    endtask

    typedef struct {
        bit    r;
        bit    p;
        int    n;
        obs_t  e;
        string nm;
    } vec_t;

    initial begin
        vec_t vt[15];
        int nh, nl, nv, nf;
        vt[0]  = '{1, 1, 5,   mk(0, 0, 0, 1, 1, 0, 0, 0),   "reset_forced"};
        vt[1]  = '{0, 1, 1,   mk(0, 0, 1, 1, 1, 1, 0, 0),   "first_after_reset"};
        vt[2]  = '{0, 1, 639, mk(639, 0, 1, 1, 1, 0, 0, 0), "col639"};
        vt[3]  = '{0, 1, 1,   mk(640, 0, 0, 1, 1, 0, 0, 0), "col640"};
        vt[4]  = '{0, 1, 16,  mk(656, 0, 0, 0, 1, 0, 0, 0), "hsync_start"};
        vt[5]  = '{0, 1, 95,  mk(751, 0, 0, 0, 1, 0, 0, 0), "hsync_last"};
        vt[6]  = '{0, 1, 1,   mk(752, 0, 0, 1, 1, 0, 0, 0), "hsync_end"};
        vt[7]  = '{0, 1, 47,  mk(799, 0, 0, 1, 1, 0, 0, 0), "col799"};
        vt[8]  = '{0, 1, 1,   mk(0, 1, 1, 1, 1, 1, 0, 0),   "line_wrap"};
        vt[9]  = '{0, 0, 1,   mk(1, 1, 1, 1, 1, 0, 0, 0),   "stall_enter"};
        vt[10] = '{0, 0, 3,   mk(1, 1, 1, 1, 1, 0, 0, 0),   "stall_hold"};
        vt[11] = '{0, 1, 1,   mk(1, 1, 1, 1, 1, 0, 0, 0),   "stall_exit"};
        vt[12] = '{0, 1, 799, mk(0, 2, 1, 1, 1, 1, 0, 0),   "line2_start"};
        vt[13] = '{1, 1, 1,   mk(0, 0, 0, 1, 1, 0, 0, 0),   "midline_reset"};
        vt[14] = '{0, 1, 1,   mk(0, 0, 1, 1, 1, 1, 0, 0),   "midline_release"};
        for (int i = 0; i < 15; i++) begin
            repeat (vt[i].n) tick(vt[i].r, vt[i].p);
            chk(vt[i].nm, 0, vt[i].e);
        end

        nh = 0; nl = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hs0) nh++;
            if (lt0) nl++;
            tick(0, 1);
        end
        cmp_int("hsync_low_cycles", nh, 96);
        cmp_int("line_ticks_per_line", nl, 1);
        chk("next_line", 0, mk(0, 1, 1, 1, 1, 1, 0, 0));

        // Small raster: one full frame at full rate.
        tick(1, 1);
        tick(1, 1);
        tick(0, 1);
        chk("s_first_after_reset", 1, mk(0, 0, 1, 1, 1, 1, 0, 0));
        nv = 0; nf = 0; nl = 0;
        for (int i = 0; i < 56; i++) begin
            if (!vs1) nv++;
            if (ft1) nf++;
            if (lt1) nl++;
            if (i == 32) chk("s_frame_tick", 1, mk(0, 4, 0, 1, 1, 1, 1, 0));
            if (i == 55) chk("s_frame_last", 1, mk(7, 6, 0, 1, 1, 0, 0, 1));
            tick(0, 1);
        end
        chk("s_frame_wrap", 1, mk(0, 0, 1, 1, 1, 1, 0, 1));
        cmp_int("s_vsync_low_cycles", nv, 8);
        cmp_int("s_frame_ticks", nf, 1);
        cmp_int("s_line_ticks", nl, 7);

        // Divide-by-2 pixel enable: frame takes 112 clks, strobes stay one clk wide.
        nf = 0; nl = 0;
        for (int i = 0; i < 112; i++) begin
            if (ft1) nf++;
            if (lt1) nl++;
            if (i == 64) chk("s_div2_frame_tick", 1, mk(0, 4, 0, 1, 1, 1, 1, 1));
            if (i == 65) chk("s_div2_after_tick", 1, mk(1, 4, 0, 1, 1, 0, 0, 2));
            tick(0, (i % 2) == 1);
        end
        chk("s_div2_period", 1, mk(0, 0, 1, 1, 1, 1, 0, 2));
        cmp_int("s_div2_frame_ticks", nf, 1);
        cmp_int("s_div2_line_ticks", nl, 7);

        // Reset mid-frame with a nonzero frame count.
        repeat (56 + 19) tick(0, 1);
        chk("s_pre_reset", 1, mk(3, 2, 1, 1, 1, 0, 0, 3));
        tick(1, 1);
        chk("s_reset_forced", 1, mk(0, 0, 0, 1, 1, 0, 0, 3));
        tick(1, 1);
        chk("s_reset_cleared", 1, mk(0, 0, 0, 1, 1, 0, 0, 0));
        tick(0, 1);
        chk("s_reset_release", 1, mk(0, 0, 1, 1, 1, 1, 0, 0));

        // Frame counter wrap after 256 frames.
        repeat (255 * 56) tick(0, 1);
        chk("s_fc255", 1, mk(0, 0, 1, 1, 1, 1, 0, 255));
        repeat (56) tick(0, 1);
        chk("s_fc_wrap", 1, mk(0, 0, 1, 1, 1, 1, 0, 0));

        tick(0, 1);
        tick(0, 1);
        cmp_int("pending_drained", pend.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
